// File: rtl/wb_stage_pipelined_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pipelined_pkg
// Shared definitions for the write-back stage:
//   - load size codes driven on load_size_in
//   - write-back FSM state encodings
//   - default datapath width
//   - helper that derives the byte-offset width from the datapath width
// -----------------------------------------------------------------------------
package wb_stage_pipelined_pkg;

  localparam int WB_DEFAULT_WORD_LEN = 32;

  localparam logic [1:0] LOAD_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LOAD_SIZE_HALF = 2'b01;
  localparam logic [1:0] LOAD_SIZE_WORD = 2'b10;
  localparam logic [1:0] LOAD_SIZE_FULL = 2'b11;

  typedef enum logic [0:0] {
    WB_STATE_READY    = 1'b0,
    WB_STATE_WAIT_MEM = 1'b1
  } wb_state_e;

  // Number of address bits that select a byte lane within one data word.
  function automatic int wb_offset_width(input int word_len);
    return $clog2(word_len / 8);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align
// Purely combinational load aligner: picks the addressed byte/half/word lane
// out of a raw memory word and sign- or zero-extends it to WORD_LEN.
// Ports:
//   data      in  WORD_LEN  raw data-memory read word
//   offset    in  OFF_W     byte offset within the word (low address bits)
//   size      in  2         LOAD_SIZE_* code
//   is_signed in  1         1 = sign-extend, 0 = zero-extend
//   value     out WORD_LEN  aligned and extended load result
// -----------------------------------------------------------------------------
module wb_load_align
  import wb_stage_pipelined_pkg::*;
#(
  parameter int WORD_LEN = WB_DEFAULT_WORD_LEN,
  parameter int OFF_W    = wb_offset_width(WORD_LEN)
) (
  input  logic [WORD_LEN-1:0] data,
  input  logic [OFF_W-1:0]    offset,
  input  logic [1:0]          size,
  input  logic                is_signed,
  output logic [WORD_LEN-1:0] value
);

  logic [OFF_W-1:0]    lane_off_s;
  logic [OFF_W-1:0]    half_off_s;
  logic [OFF_W-1:0]    word_off_s;
  logic [OFF_W+2:0]    shamt_s;
  logic [WORD_LEN-1:0] shifted_s;

  // Misaligned halves/words round down to their natural boundary; on a
  // 32-bit build the word offset collapses to zero.
  assign half_off_s = (offset >> 1'b1) << 1'b1;
  assign word_off_s = (offset >> 2'd2) << 2'd2;

  // Choose the byte offset of the lane to extract.
  always_comb begin
    case (size)
      LOAD_SIZE_BYTE: lane_off_s = offset;
      LOAD_SIZE_HALF: lane_off_s = half_off_s;
      LOAD_SIZE_WORD: lane_off_s = word_off_s;
      LOAD_SIZE_FULL: lane_off_s = {OFF_W{1'b0}};
      default:        lane_off_s = {OFF_W{1'b0}};
    endcase
  end

  assign shamt_s   = {lane_off_s, 3'b000};
  assign shifted_s = data >> shamt_s;

  // Extend the selected lane to the full datapath width.
  always_comb begin
    case (size)
      LOAD_SIZE_BYTE: value = is_signed ? WORD_LEN'($signed(shifted_s[7:0]))
                                        : WORD_LEN'(shifted_s[7:0]);
      LOAD_SIZE_HALF: value = is_signed ? WORD_LEN'($signed(shifted_s[15:0]))
                                        : WORD_LEN'(shifted_s[15:0]);
      LOAD_SIZE_WORD: value = is_signed ? WORD_LEN'($signed(shifted_s[31:0]))
                                        : WORD_LEN'(shifted_s[31:0]);
      LOAD_SIZE_FULL: value = data;
      default:        value = data;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// -----------------------------------------------------------------------------
// wb_stage_pipelined
// Registered write-back stage. Captures the retiring instruction from MEM,
// waits for multi-cycle loads (stalling upstream), aligns/extends load data and
// drives the register-file write port (which doubles as the forwarding source).
// Optional feature macro: WB_RETIRE_COUNT_EN enables the retired-instruction
// counter; when undefined retired_count is tied to zero.
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   freeze, flush                pipeline hold / discard pending entry
//   in_valid, pc_in, wb_en_in,
//   dest_in, mem_read_in,
//   load_size_in, load_signed_in,
//   alu_res_in                   incoming instruction from MEM
//   mem_rdata, mem_rdata_valid   data-memory read return
//   stall                        combinational hold to upstream stages
//   wb_en, wb_dest, wb_value     register-file write port
//   pc_out                       PC of instruction being written back
//   retired_count                retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage_pipelined
  import wb_stage_pipelined_pkg::*;
#(
  parameter int WORD_LEN     = WB_DEFAULT_WORD_LEN,
  parameter int ADDRESS_LEN  = 32,
  parameter int REG_ADDR_LEN = 4,
  parameter int COUNT_LEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [ADDRESS_LEN-1:0]  pc_in,
  input  logic                    wb_en_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic                    mem_read_in,
  input  logic [1:0]              load_size_in,
  input  logic                    load_signed_in,
  input  logic [WORD_LEN-1:0]     alu_res_in,
  input  logic [WORD_LEN-1:0]     mem_rdata,
  input  logic                    mem_rdata_valid,
  output logic                    stall,
  output logic                    wb_en,
  output logic [REG_ADDR_LEN-1:0] wb_dest,
  output logic [WORD_LEN-1:0]     wb_value,
  output logic [ADDRESS_LEN-1:0]  pc_out,
  output logic [COUNT_LEN-1:0]    retired_count
);

  localparam int OFF_W = wb_offset_width(WORD_LEN);

  wb_state_e               state_q, state_d;
  logic [REG_ADDR_LEN-1:0] hold_dest_q, hold_dest_d;
  logic [ADDRESS_LEN-1:0]  hold_pc_q, hold_pc_d;
  logic [1:0]              hold_size_q, hold_size_d;
  logic                    hold_signed_q, hold_signed_d;
  logic [OFF_W-1:0]        hold_off_q, hold_off_d;

  logic                    wb_en_q, wb_en_d;
  logic [REG_ADDR_LEN-1:0] wb_dest_q, wb_dest_d;
  logic [WORD_LEN-1:0]     wb_value_q, wb_value_d;
  logic [ADDRESS_LEN-1:0]  pc_out_q, pc_out_d;

  logic [OFF_W-1:0]        align_off_s;
  logic [1:0]              align_size_s;
  logic                    align_signed_s;
  logic [WORD_LEN-1:0]     aligned_s;

  // The single aligner sees the live load attributes in READY (zero-wait load)
  // and the held ones while a load is outstanding.
  always_comb begin
    if (state_q == WB_STATE_WAIT_MEM) begin
      align_off_s    = hold_off_q;
      align_size_s   = hold_size_q;
      align_signed_s = hold_signed_q;
    end else begin
      align_off_s    = alu_res_in[OFF_W-1:0];
      align_size_s   = load_size_in;
      align_signed_s = load_signed_in;
    end
  end

  wb_load_align #(
    .WORD_LEN (WORD_LEN),
    .OFF_W    (OFF_W)
  ) u_load_align (
    .data      (mem_rdata),
    .offset    (align_off_s),
    .size      (align_size_s),
    .is_signed (align_signed_s),
    .value     (aligned_s)
  );

  // Flush suppresses the stall for a load that is being discarded in READY.
  assign stall = (state_q == WB_STATE_WAIT_MEM) |
                 ((state_q == WB_STATE_READY) & in_valid & mem_read_in &
                  ~mem_rdata_valid & ~flush);

  // Next-state, held-field and output-register computation.
  always_comb begin
    state_d       = state_q;
    hold_dest_d   = hold_dest_q;
    hold_pc_d     = hold_pc_q;
    hold_size_d   = hold_size_q;
    hold_signed_d = hold_signed_q;
    hold_off_d    = hold_off_q;
    wb_en_d       = 1'b0;
    wb_dest_d     = wb_dest_q;
    wb_value_d    = wb_value_q;
    pc_out_d      = pc_out_q;
    case (state_q)
      WB_STATE_READY: begin
        if (flush) begin
          state_d = WB_STATE_READY;
        end else if (in_valid && !freeze) begin
          if (!mem_read_in) begin
            wb_en_d    = wb_en_in;
            wb_dest_d  = dest_in;
            wb_value_d = alu_res_in;
            pc_out_d   = pc_in;
          end else if (mem_rdata_valid) begin
            wb_en_d    = 1'b1;
            wb_dest_d  = dest_in;
            wb_value_d = aligned_s;
            pc_out_d   = pc_in;
          end else begin
            hold_dest_d   = dest_in;
            hold_pc_d     = pc_in;
            hold_size_d   = load_size_in;
            hold_signed_d = load_signed_in;
            hold_off_d    = alu_res_in[OFF_W-1:0];
            state_d       = WB_STATE_WAIT_MEM;
          end
        end else begin
          state_d = WB_STATE_READY;
        end
      end
      WB_STATE_WAIT_MEM: begin
        // freeze is deliberately ignored here; flush abandons the load.
        if (flush) begin
          state_d = WB_STATE_READY;
        end else if (mem_rdata_valid) begin
          wb_en_d    = 1'b1;
          wb_dest_d  = hold_dest_q;
          wb_value_d = aligned_s;
          pc_out_d   = hold_pc_q;
          state_d    = WB_STATE_READY;
        end else begin
          state_d = WB_STATE_WAIT_MEM;
        end
      end
      default: begin
        state_d = WB_STATE_READY;
      end
    endcase
  end

  // State, held fields and registered write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WB_STATE_READY;
      hold_dest_q   <= {REG_ADDR_LEN{1'b0}};
      hold_pc_q     <= {ADDRESS_LEN{1'b0}};
      hold_size_q   <= 2'b00;
      hold_signed_q <= 1'b0;
      hold_off_q    <= {OFF_W{1'b0}};
      wb_en_q       <= 1'b0;
      wb_dest_q     <= {REG_ADDR_LEN{1'b0}};
      wb_value_q    <= {WORD_LEN{1'b0}};
      pc_out_q      <= {ADDRESS_LEN{1'b0}};
    end else begin
      state_q       <= state_d;
      hold_dest_q   <= hold_dest_d;
      hold_pc_q     <= hold_pc_d;
      hold_size_q   <= hold_size_d;
      hold_signed_q <= hold_signed_d;
      hold_off_q    <= hold_off_d;
      wb_en_q       <= wb_en_d;
      wb_dest_q     <= wb_dest_d;
      wb_value_q    <= wb_value_d;
      pc_out_q      <= pc_out_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_dest  = wb_dest_q;
  assign wb_value = wb_value_q;
  assign pc_out   = pc_out_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [COUNT_LEN-1:0] count_q, count_d;

  // Count every cycle in which the write strobe is high; wraps naturally.
  always_comb begin
    if (wb_en_q) begin
      count_d = count_q + COUNT_LEN'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {COUNT_LEN{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;
`else
  assign retired_count = {COUNT_LEN{1'b0}};
`endif

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_pipelined
// Self-checking bench for wb_stage_pipelined (WORD_LEN=32, COUNT_LEN=4).
// Directed scenarios followed by randomized traffic, compared against a
// transaction-level reference model of the write-back rules.
// -----------------------------------------------------------------------------
module tb_wb_stage_pipelined;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze, flush, in_valid, wb_en_in, mem_read_in;
  logic        load_signed_in, mem_rdata_valid;
  logic [31:0] pc_in, alu_res_in, mem_rdata;
  logic [3:0]  dest_in;
  logic [1:0]  load_size_in;
  logic        stall, wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value, pc_out;
  logic [CNT_W-1:0] retired_count;

  wb_stage_pipelined #(
    .WORD_LEN(32), .ADDRESS_LEN(32), .REG_ADDR_LEN(4), .COUNT_LEN(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .dest_in(dest_in),
    .mem_read_in(mem_read_in), .load_size_in(load_size_in),
    .load_signed_in(load_signed_in), .alu_res_in(alu_res_in),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .stall(stall), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .pc_out(pc_out), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend;
  logic [3:0]  m_dest;
  logic [31:0] m_pc;
  int          m_size, m_off;
  bit          m_sgn;
  bit          e_wb_en;
  logic [3:0]  e_dest;
  logic [31:0] e_value, e_pc;
  int          m_cnt;

  // Lane extraction by arithmetic: lane index = offset / lane bytes.
  function automatic logic [31:0] ref_align(input logic [31:0] data, input int off,
                                            input int size, input bit sgn);
    longint unsigned v;
    int bits;
    int lane;
    case (size)
      0:       bits = 8;
      1:       bits = 16;
      default: bits = 32;
    endcase
    lane = off / (bits / 8);
    v = (64'(data) >> (lane * bits)) & ((64'd1 << bits) - 64'd1);
    if (sgn && v[bits-1]) v = v | (~64'd0 << bits);
    return v[31:0];
  endfunction

  function automatic int exp_count();
`ifdef WB_RETIRE_COUNT_EN
    return m_cnt % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_pend = 1'b0; m_dest = '0; m_pc = '0; m_size = 0; m_off = 0; m_sgn = 1'b0;
    e_wb_en = 1'b0; e_dest = '0; e_value = '0; e_pc = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit nxt;
    nxt = 1'b0;
    if (m_pend) begin
      if (flush) m_pend = 1'b0;
      else if (mem_rdata_valid) begin
        nxt = 1'b1; e_dest = m_dest; e_pc = m_pc;
        e_value = ref_align(mem_rdata, m_off, m_size, m_sgn);
        m_pend = 1'b0;
      end
    end else if (in_valid && !freeze && !flush) begin
      if (!mem_read_in) begin
        nxt = wb_en_in; e_dest = dest_in; e_value = alu_res_in; e_pc = pc_in;
      end else if (mem_rdata_valid) begin
        nxt = 1'b1; e_dest = dest_in; e_pc = pc_in;
        e_value = ref_align(mem_rdata, int'(alu_res_in[1:0]), int'(load_size_in), load_signed_in);
      end else begin
        m_pend = 1'b1; m_dest = dest_in; m_pc = pc_in; m_size = int'(load_size_in);
        m_off = int'(alu_res_in[1:0]); m_sgn = load_signed_in;
      end
    end
    e_wb_en = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_en_in = 1'b0; mem_read_in = 1'b0;
    load_signed_in = 1'b0; mem_rdata_valid = 1'b0; pc_in = '0; alu_res_in = '0;
    mem_rdata = '0; dest_in = '0; load_size_in = 2'b00;
  endtask

  task automatic set_alu(input logic [3:0] d, input logic [31:0] v, input logic [31:0] pc,
                         input logic wen);
    idle_inputs();
    in_valid = 1'b1; wb_en_in = wen; dest_in = d; alu_res_in = v; pc_in = pc;
  endtask

  task automatic set_load(input logic [3:0] d, input logic [31:0] addr, input logic [31:0] pc,
                          input logic [1:0] sz, input logic sgn, input logic [31:0] data,
                          input logic vld);
    idle_inputs();
    in_valid = 1'b1; wb_en_in = 1'b1; mem_read_in = 1'b1; dest_in = d; alu_res_in = addr;
    pc_in = pc; load_size_in = sz; load_signed_in = sgn; mem_rdata = data;
    mem_rdata_valid = vld;
  endtask

  // One clock: check stall, advance model, sample outputs on the falling edge.
  task automatic step();
    #1;
    check_eq("stall", stall, m_pend || (in_valid && mem_read_in && !mem_rdata_valid && !flush));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_eq("wb_en", wb_en, e_wb_en);
    check_eq("wb_dest", wb_dest, e_dest);
    check_eq("wb_value", wb_value, e_value);
    check_eq("pc_out", pc_out, e_pc);
    check_eq("retired_count", retired_count, exp_count());
    if (e_wb_en) m_cnt++;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    check_eq("rst_wb_en", wb_en, 0);
    check_eq("rst_wb_dest", wb_dest, 0);
    check_eq("rst_wb_value", wb_value, 0);
    check_eq("rst_pc_out", pc_out, 0);
    check_eq("rst_count", retired_count, 0);
    check_eq("rst_stall", stall, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n_stall, n_pulse;

  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // ALU op retires after one cycle, then strobe drops.
    set_alu(4'd5, 32'h0000_1234, 32'h0000_0100, 1'b1);
    step();
    check_eq("t1_wb_en", wb_en, 1);
    check_eq("t1_dest", wb_dest, 5);
    check_eq("t1_value", wb_value, 32'h0000_1234);
    idle_inputs();
    step();
    check_eq("t1_wb_en_drop", wb_en, 0);

    // Zero-wait signed byte load at offset 3.
    set_load(4'd7, 32'h0000_2003, 32'h0000_0104, 2'b00, 1'b1, 32'h80FF_7F01, 1'b1);
    #1 check_eq("t2_no_stall", stall, 0);
    step();
    check_eq("t2_value", wb_value, 32'hFFFF_FF80);
    idle_inputs();
    step();

    // Half load, data arrives three cycles after capture.
    n_stall = 0; n_pulse = 0;
    set_load(4'd9, 32'h0000_3002, 32'h0000_0108, 2'b01, 1'b0, 32'hBEEF_1234, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        idle_inputs();
        mem_rdata = 32'hBEEF_1234;
        mem_rdata_valid = (i == 3);
      end
      #1 if (stall) n_stall++;
      step();
      if (wb_en) n_pulse++;
      if (wb_en) check_eq("t3_value", wb_value, 32'h0000_BEEF);
    end
    check_eq("t3_stall_cycles", n_stall, 4);
    check_eq("t3_pulses", n_pulse, 1);

    // Flush in WAIT_MEM; late valid for the abandoned load is ignored.
    n_pulse = 0;
    set_load(4'd3, 32'h0000_4000, 32'h0000_010C, 2'b10, 1'b0, 32'h1111_2222, 1'b0);
    step();
    idle_inputs(); step();
    idle_inputs(); flush = 1'b1; step();
    idle_inputs(); mem_rdata = 32'hDEAD_BEEF; mem_rdata_valid = 1'b1;
    #1 check_eq("t4_stall_after_flush", stall, 0);
    step();
    if (wb_en) n_pulse++;
    idle_inputs(); step();
    if (wb_en) n_pulse++;
    check_eq("t4_no_pulse", n_pulse, 0);

    // Async reset between edges while a load is outstanding.
    set_load(4'd2, 32'h0000_5001, 32'h0000_0110, 2'b00, 1'b0, 32'h0, 1'b0);
    step();
    idle_inputs(); step();
    #2;
    do_reset();
    set_alu(4'd11, 32'hCAFE_0001, 32'h0000_0114, 1'b1);
    step();
    check_eq("t5_after_rst_value", wb_value, 32'hCAFE_0001);
    idle_inputs(); step();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      freeze          = ($urandom_range(0, 9) == 0);
      flush           = ($urandom_range(0, 19) == 0);
      in_valid        = ($urandom_range(0, 9) < 7);
      mem_read_in     = ($urandom_range(0, 9) < 4);
      wb_en_in        = mem_read_in ? 1'b1 : 1'($urandom_range(0, 1));
      dest_in         = 4'($urandom);
      pc_in           = $urandom;
      alu_res_in      = $urandom;
      load_size_in    = 2'($urandom);
      load_signed_in  = 1'($urandom_range(0, 1));
      mem_rdata       = $urandom;
      mem_rdata_valid = ($urandom_range(0, 1) == 1);
      step();
    end

    // 17 retires on a 4-bit counter wrap to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_alu(4'(i), 32'(i), 32'(i * 4), 1'b1);
      step();
    end
    idle_inputs(); step();
`ifdef WB_RETIRE_COUNT_EN
    check_eq("t6_count_wrap", retired_count, 1);
`else
    check_eq("t6_count_tied", retired_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
Registered, parametrised write-back stage for the ARM pipeline.
- Captures the retiring instruction from the MEM stage.
- Handles multi-cycle data-memory reads through a valid handshake, with a stall back to the pipeline while waiting.
- Aligns and extends byte/halfword/word loads.
- Drives the register-file write port, which also serves as the forwarding source.

Parameters:
WORD_LEN, 32, datapath width; legal values 32 or 64
ADDRESS_LEN, 32, PC width
REG_ADDR_LEN, 4, register index width
COUNT_LEN, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  global pipeline hold; blocks capture of a new entry
flush  in  1  discard pending entry (branch/exception)
in_valid  in  1  MEM stage presents a valid instruction
pc_in  in  ADDRESS_LEN  PC of incoming instruction
wb_en_in  in  1  instruction writes a register
dest_in  in  REG_ADDR_LEN  destination register
mem_read_in  in  1  instruction is a load
load_size_in  in  2  00 byte, 01 half, 10 word32, 11 full WORD_LEN
load_signed_in  in  1  1 = sign-extend, 0 = zero-extend
alu_res_in  in  WORD_LEN  ALU result / load address
mem_rdata  in  WORD_LEN  data-memory read data
mem_rdata_valid  in  1  mem_rdata valid this cycle
stall  out  1  hold upstream stages
wb_en  out  1  register-file write strobe, one cycle per retired instruction
wb_dest  out  REG_ADDR_LEN  register-file write index
wb_value  out  WORD_LEN  register-file write data
pc_out  out  ADDRESS_LEN  PC of instruction being written back
retired_count  out  COUNT_LEN  retired-instruction count

Behaviour:
- Reset (async, rst=1): state=READY; all held fields=0; wb_en, wb_dest, wb_value, pc_out, retired_count all 0.
- States: READY, WAIT_MEM.
- Capture condition: state=READY, in_valid=1, freeze=0, flush=0.
- Non-load (mem_read_in=0) captured at edge N:
  - wb_value=alu_res_in, wb_dest=dest_in, pc_out=pc_in.
  - wb_en=wb_en_in, valid for cycle N+1 only.
  - Fixed latency of 1 cycle.
- Load captured with mem_rdata_valid=1 in the same cycle: aligned data is registered at edge N; retires in N+1; state stays READY.
- Load captured with mem_rdata_valid=0:
  - Register dest, pc, size, signedness and the low alu_res bits; go to WAIT_MEM.
  - In WAIT_MEM, on mem_rdata_valid=1, register the aligned data, pulse wb_en next cycle, return to READY.
- stall (combinational) = (state=WAIT_MEM) OR (state=READY AND in_valid AND mem_read_in AND NOT mem_rdata_valid AND NOT flush).
- wb_en is 0 in every cycle that does not follow a retire edge. wb_dest, wb_value and pc_out hold their last values.
- Alignment (offset = alu_res low log2(WORD_LEN/8) bits):
  - Byte: selects lane offset.
  - Half: selects lane offset>>1; offset bit0 ignored, so misaligned accesses round down.
  - Word32: offset>>2 selects the word; on 32-bit builds this equals full.
  - Full: no shift.
  - Extension to WORD_LEN follows load_signed_in.
- flush has priority over capture and over WAIT_MEM:
  - Next state is READY; no wb_en pulse follows.
  - A mem_rdata_valid arriving in the flush cycle or later for the abandoned load is ignored.
- freeze has no effect in WAIT_MEM; the pending load still completes.
- Simultaneous flush and mem_rdata_valid in WAIT_MEM: flush wins, nothing is retired.
- Reset mid-WAIT_MEM: returns to READY immediately; no retire.

Optional Feature:
WB_RETIRE_COUNT_EN
- Defined: retired_count increments by 1 on every cycle where wb_en=1. It wraps modulo 2^COUNT_LEN and clears on rst.
- Undefined: retired_count is tied to 0 and no counter flops are generated. The port is always present.

Decomposition:
- defines.v gains:
  - LOAD_SIZE_BYTE/HALF/WORD/FULL codes.
  - WB_STATE_READY/WB_STATE_WAIT_MEM encodings.
  - Default WORD_LEN.
- One combinational sub-module, wb_load_align: takes raw data, offset, size and signed flag, and returns the extended value. It is instantiated once, on the mem_rdata path.

Test Plan:
- ALU op: in_valid=1, wb_en_in=1, dest=5, alu_res=0x1234 -> next cycle wb_en=1, wb_dest=5, wb_value=0x1234; cycle after that wb_en=0.
- Zero-wait signed byte load: mem_rdata=0x80FF7F01, addr low bits=3, size=byte, signed=1, valid same cycle -> wb_value=0xFFFFFF80 one cycle later, stall never asserted.
- Multi-cycle half load: valid arrives 3 cycles late, mem_rdata=0xBEEF1234, addr low bits=2, unsigned -> stall high for 4 cycles, wb_en pulses once with 0x0000BEEF.
- Flush during WAIT_MEM, valid asserted 1 cycle later -> stall drops after flush, no wb_en pulse, state READY.
- Async reset asserted mid-WAIT_MEM between clock edges -> outputs 0 immediately, stall=0; a following ALU op retires normally.
- With WB_RETIRE_COUNT_EN and COUNT_LEN=4: 17 retires -> retired_count=1 (wrap). Without the macro: retired_count stays 0.
